// File: rtl/datatypesPkg.sv
`default_nettype none
// ============================================================================
// Module      : datatypesPkg
// Description : Shared aligner types plus the result-reader constants and
//               reader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package datatypesPkg;

    // Traceback direction symbol carried on the result stream
    typedef enum logic [1:0] {
        DIR_DIAG = 2'd0,
        DIR_UP   = 2'd1,
        DIR_LEFT = 2'd2,
        DIR_NONE = 2'd3
    } direction;

    // Nucleotide encoding used across the aligner
    typedef enum logic [1:0] {
        BASE_A = 2'd0,
        BASE_C = 2'd1,
        BASE_G = 2'd2,
        BASE_T = 2'd3
    } dna_base;

    localparam logic [5:0] MED_STATUS_ADDR   = 6'd0;
    localparam logic [5:0] MED_DATA_BASE     = 6'd1;
    localparam int         MED_SYMS_PER_WORD = 32;

    // Result reader sequencing
    typedef enum logic [3:0] {
        RD_IDLE      = 4'd0,
        RD_POLL_REQ  = 4'd1,
        RD_POLL_WAIT = 4'd2,
        RD_POLL_GAP  = 4'd3,
        RD_DATA_REQ  = 4'd4,
        RD_DATA_WAIT = 4'd5,
        RD_DRAIN     = 4'd6,
        RD_DONE      = 4'd7,
        RD_TIMEOUT   = 4'd8
    } med_rd_state;

endpackage
`default_nettype wire

// File: rtl/med_dir_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : med_dir_unpacker
// Description : Holds one 64-bit result word and hands out its 32 two-bit
//               direction symbols, lowest symbol first, one per handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module med_dir_unpacker
    import datatypesPkg::*;
(
    input  logic        clk,
    input  logic        rst,        // synchronous, active-low
    input  logic        i_load,
    input  logic [63:0] i_word,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [1:0]  o_data,
    output logic [4:0]  o_idx,
    output logic        o_last
);

    logic [63:0] r_word;
    logic        r_valid;
    logic [4:0]  r_idx;
    logic        w_fire;

    assign w_fire = r_valid & i_ready;

    // Load a fresh word, or shift out the current symbol on each handshake
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_word  <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
        end else if (i_load) begin
            r_word  <= i_word;
            r_valid <= 1'b1;
            r_idx   <= '0;
        end else if (w_fire) begin
            r_word <= {2'b00, r_word[63:2]};
            r_idx  <= r_idx + 5'd1;
            if (o_last) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_word[1:0];
    assign o_idx   = r_idx;
    assign o_last  = (r_idx == 5'(MED_SYMS_PER_WORD - 1));

endmodule
`default_nettype wire

// File: rtl/med_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : med_result_reader
// Description : Avalon-MM read initiator that polls the solver status word,
//               fetches the packed result words and streams them out as
//               two-bit direction symbols.
// Revision    : 1.0 - initial release
// ============================================================================
module med_result_reader
    import datatypesPkg::*;
#(
    parameter int NUM_WORDS  = 2,
    parameter int POLL_GAP   = 4,
    parameter int POLL_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst,        // synchronous, active-low
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [5:0]  avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [63:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic [1:0]  dir_data,
    output logic        dir_valid,
    input  logic        dir_ready,
    output logic        dir_last
);

    localparam int PCW = $clog2(POLL_LIMIT + 1);
    localparam int GCW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [PCW-1:0] c_poll_limit = PCW'(POLL_LIMIT);
    localparam logic [GCW-1:0] c_gap_last   = GCW'(POLL_GAP - 1);
    localparam logic [5:0]     c_last_word  = 6'(NUM_WORDS - 1);

    med_rd_state    r_state;
    med_rd_state    w_next;
    med_rd_state    w_poll_dest;
    logic [PCW-1:0] r_poll_cnt;
    logic [PCW-1:0] w_poll_inc;
    logic [PCW-1:0] w_poll_seen;
    logic [GCW-1:0] r_gap_cnt;
    logic [5:0]     r_word_idx;
    logic           w_accept;
    logic           w_rsp_poll;
    logic           w_rsp_data;
    logic           w_fire;
    logic           w_sym_last;
    logic [4:0]     w_sym_idx;
    logic           w_word_end;

    assign w_accept   = avm_read & ~avm_waitrequest;
    assign w_poll_inc = r_poll_cnt + PCW'(1);
    // Status data can land in the same cycle the request is accepted, before
    // the poll counter has been bumped
    assign w_poll_seen = (r_state == RD_POLL_REQ) ? w_poll_inc : r_poll_cnt;
    assign w_rsp_poll  = avm_readdatavalid &
                         ((r_state == RD_POLL_WAIT) || ((r_state == RD_POLL_REQ) && w_accept));
    assign w_rsp_data  = avm_readdatavalid &
                         ((r_state == RD_DATA_WAIT) || ((r_state == RD_DATA_REQ) && w_accept));
    assign w_fire      = dir_valid & dir_ready;
    assign w_word_end  = (r_state == RD_DRAIN) & w_fire & w_sym_last;

    // Where a returned status word sends the sequencer
    always_comb begin
        w_poll_dest = RD_POLL_GAP;
        if (avm_readdata[0]) begin
            w_poll_dest = RD_DATA_REQ;
        end else if (w_poll_seen == c_poll_limit) begin
            w_poll_dest = RD_TIMEOUT;
        end else if (POLL_GAP == 0) begin
            w_poll_dest = RD_POLL_REQ;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Avalon/status output decode
    always_comb begin
        w_next      = r_state;
        avm_read    = 1'b0;
        avm_address = MED_STATUS_ADDR;
        busy        = 1'b1;
        done        = 1'b0;
        timeout     = 1'b0;
        case (r_state)
            RD_IDLE: begin
                busy = 1'b0;
                if (start) w_next = RD_POLL_REQ;
            end
            RD_POLL_REQ: begin
                avm_read = 1'b1;
                if (w_accept) w_next = avm_readdatavalid ? w_poll_dest : RD_POLL_WAIT;
            end
            RD_POLL_WAIT: begin
                if (avm_readdatavalid) w_next = w_poll_dest;
            end
            RD_POLL_GAP: begin
                if (r_gap_cnt == c_gap_last) w_next = RD_POLL_REQ;
            end
            RD_DATA_REQ: begin
                avm_read    = 1'b1;
                avm_address = r_word_idx + MED_DATA_BASE;
                if (w_accept) w_next = avm_readdatavalid ? RD_DRAIN : RD_DATA_WAIT;
            end
            RD_DATA_WAIT: begin
                if (avm_readdatavalid) w_next = RD_DRAIN;
            end
            RD_DRAIN: begin
                if (w_word_end) w_next = (r_word_idx == c_last_word) ? RD_DONE : RD_DATA_REQ;
            end
            RD_DONE: begin
                busy   = 1'b0;
                done   = 1'b1;
                w_next = RD_IDLE;
            end
            RD_TIMEOUT: begin
                busy    = 1'b0;
                timeout = 1'b1;
                w_next  = RD_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = RD_IDLE;
            end
        endcase
    end

    // Poll, gap and word counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_poll_cnt <= '0;
            r_gap_cnt  <= '0;
            r_word_idx <= '0;
        end else begin
            if ((r_state == RD_IDLE) && start) begin
                r_poll_cnt <= '0;
            end else if ((r_state == RD_POLL_REQ) && w_accept) begin
                r_poll_cnt <= w_poll_inc;
            end

            if (r_state == RD_POLL_GAP) begin
                r_gap_cnt <= r_gap_cnt + GCW'(1);
            end else begin
                r_gap_cnt <= '0;
            end

            if (w_rsp_poll && avm_readdata[0]) begin
                r_word_idx <= '0;
            end else if (w_word_end && (r_word_idx != c_last_word)) begin
                r_word_idx <= r_word_idx + 6'd1;
            end
        end
    end

    med_dir_unpacker u_unpacker (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_rsp_data),
        .i_word  (avm_readdata),
        .i_ready (dir_ready),
        .o_valid (dir_valid),
        .o_data  (dir_data),
        .o_idx   (w_sym_idx),
        .o_last  (w_sym_last)
    );

    assign dir_last = dir_valid & (w_sym_idx == 5'(MED_SYMS_PER_WORD - 1)) &
                      (r_word_idx == c_last_word);

endmodule
`default_nettype wire

// File: tb/tb_med_result_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_med_result_reader
// Description : Directed bench for med_result_reader with a behavioural
//               Avalon responder and a stream monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_med_result_reader;

    localparam int NW  = 2;
    localparam int GAP = 4;
    localparam int LIM = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, timeout;
    logic [5:0]  avm_address;
    logic        avm_read, avm_waitrequest, avm_readdatavalid;
    logic [63:0] avm_readdata;
    logic [1:0]  dir_data;
    logic        dir_valid, dir_last;
    logic        dir_ready = 1'b1;

    always #5 clk = ~clk;

    med_result_reader #(.NUM_WORDS(NW), .POLL_GAP(GAP), .POLL_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .timeout(timeout),
        .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .dir_data(dir_data), .dir_valid(dir_valid), .dir_ready(dir_ready), .dir_last(dir_last)
    );

    // ---------------- responder configuration and state ----------------
    logic [63:0] mem [0:2];
    int          fin_after = 0;   // status polls answered 0 before finished
    int          lat       = 0;   // 0: data in accept cycle, N: N cycles later
    bit          wait_arm  = 1'b0;
    bit          force_rdv = 1'b0;
    bit          log_clr   = 1'b0;
    int          rdy_mode  = 0;
    int          stat_n    = 0;
    int          pend_cnt  = 0;
    int          wr_seen   = 0;
    logic [63:0] pend_data = '0;
    logic [63:0] rsp_now;
    logic        w_acc;
    int          rdy_ph = 0;

    assign w_acc           = avm_read && !avm_waitrequest;
    assign avm_waitrequest = wait_arm && avm_read && (avm_address == 6'd1) && (wr_seen < 5);

    always_comb begin
        rsp_now = (avm_address == 6'd0) ? {63'd0, (stat_n >= fin_after)} : mem[avm_address[1:0]];
        if (lat == 0) begin
            avm_readdatavalid = w_acc || force_rdv;
            avm_readdata      = rsp_now;
        end else begin
            avm_readdatavalid = (pend_cnt == 1) || force_rdv;
            avm_readdata      = pend_data;
        end
        if (force_rdv) avm_readdata = '1;
    end

    always @(posedge clk) begin
        if (log_clr) begin
            stat_n   <= 0;
            pend_cnt <= 0;
            wr_seen  <= 0;
        end else begin
            if (avm_waitrequest) wr_seen <= wr_seen + 1;
            if (w_acc) begin
                if (avm_address == 6'd0) stat_n <= stat_n + 1;
                if (lat > 0) begin
                    pend_cnt  <= lat;
                    pend_data <= rsp_now;
                end
            end else if (pend_cnt != 0) begin
                pend_cnt <= pend_cnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        rdy_ph    <= (rdy_ph + 1) % 4;
        dir_ready <= (rdy_mode == 0) ? 1'b1 : ((rdy_ph == 0) || (rdy_ph == 3));
    end

    // ---------------- monitor (sampled on falling edge) ----------------
    int         cyc = 0, nstat = 0, ndata = 0, nsym = 0, nlast = 0, last_pos = -1;
    int         n_done = 0, n_tmo = 0, n_dv = 0, ws_cyc = 0, n_a1 = 0, sym_at_a2 = -1;
    int         avm_stab_err = 0, dat_stab_err = 0, overlap_err = 0;
    int         stat_cyc [8];
    logic [5:0] data_addr [8];
    logic [1:0] sym [128];
    logic       prev_wait = 1'b0, prev_stall = 1'b0;
    logic [5:0] prev_addr = '0;
    logic [1:0] prev_data = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (log_clr) begin
            nstat <= 0; ndata <= 0; nsym <= 0; nlast <= 0; last_pos <= -1;
            n_done <= 0; n_tmo <= 0; n_dv <= 0; ws_cyc <= 0; n_a1 <= 0; sym_at_a2 <= -1;
            avm_stab_err <= 0; dat_stab_err <= 0; overlap_err <= 0;
            prev_wait <= 1'b0; prev_stall <= 1'b0;
        end else begin
            if (w_acc) begin
                if (avm_address == 6'd0) begin
                    if (nstat < 8) stat_cyc[nstat] <= cyc;
                    nstat <= nstat + 1;
                end else begin
                    if (ndata < 8) data_addr[ndata] <= avm_address;
                    ndata <= ndata + 1;
                    if (avm_address == 6'd1) n_a1 <= n_a1 + 1;
                    if (avm_address == 6'd2) sym_at_a2 <= nsym;
                end
            end
            if (avm_read && avm_waitrequest) ws_cyc <= ws_cyc + 1;
            if (prev_wait && (!avm_read || avm_address != prev_addr)) avm_stab_err <= avm_stab_err + 1;
            prev_wait <= avm_read && avm_waitrequest;
            prev_addr <= avm_address;
            if (dir_valid && avm_read) overlap_err <= overlap_err + 1;
            if (prev_stall && (!dir_valid || dir_data != prev_data)) dat_stab_err <= dat_stab_err + 1;
            prev_stall <= dir_valid && !dir_ready;
            prev_data  <= dir_data;
            if (dir_valid) n_dv <= n_dv + 1;
            if (dir_valid && dir_ready) begin
                if (nsym < 128) sym[nsym] <= dir_data;
                nsym <= nsym + 1;
                if (dir_last) begin
                    nlast    <= nlast + 1;
                    last_pos <= nsym;
                end
            end
            if (done)    n_done <= n_done + 1;
            if (timeout) n_tmo  <= n_tmo + 1;
        end
    end

    // ---------------- checking helpers ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int exp_sym(input int n);
        logic [63:0] s;
        s = mem[(n / 32) + 1] >> (2 * (n % 32));
        return int'(s[1:0]);
    endfunction

    task automatic chk_syms(input string tag, input int cnt);
        int bad = 0;
        for (int i = 0; i < cnt; i++) begin
            if (int'(sym[i]) != exp_sym(i)) bad++;
        end
        chk({tag, "_sym_errs"}, bad, 0);
    endtask

    task automatic clr_log;
        @(posedge clk); log_clr = 1'b1;
        @(posedge clk);
        @(posedge clk); log_clr = 1'b0;
    endtask

    task automatic pulse_start;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_end(input int bound, input string tag);
        int k = 0;
        while (n_done == 0 && n_tmo == 0 && k < bound) begin
            @(posedge clk);
            k++;
        end
        chk({tag, "_finished"}, int'(n_done != 0 || n_tmo != 0), 1);
        repeat (6) @(posedge clk);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},    int'(busy), 0);
        chk({tag, "_done"},    int'(done), 0);
        chk({tag, "_timeout"}, int'(timeout), 0);
        chk({tag, "_read"},    int'(avm_read), 0);
        chk({tag, "_addr"},    int'(avm_address), 0);
        chk({tag, "_dvalid"},  int'(dir_valid), 0);
        chk({tag, "_dlast"},   int'(dir_last), 0);
        chk({tag, "_ddata"},   int'(dir_data), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end expected end");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int k;
        int nz;
        mem[0] = '0; mem[1] = '0; mem[2] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("rst");
        rst = 1'b1;

        // Finished on third poll, zero-latency responder, gap of 4 idle cycles
        mem[1] = 64'h0123_4567_89AB_CDEF;
        mem[2] = 64'hFEDC_BA98_7654_3210;
        fin_after = 2; lat = 0; wait_arm = 1'b0; rdy_mode = 0;
        clr_log();
        pulse_start();
        wait_end(500, "t1");
        chk("t1_status_reads", nstat, 3);
        chk("t1_gap01", stat_cyc[1] - stat_cyc[0], 5);
        chk("t1_gap12", stat_cyc[2] - stat_cyc[1], 5);
        chk("t1_data_reads", ndata, 2);
        chk("t1_addr_a", int'(data_addr[0]), 1);
        chk("t1_addr_b", int'(data_addr[1]), 2);
        chk("t1_nsym", nsym, 64);
        chk("t1_nlast", nlast, 1);
        chk("t1_last_pos", last_pos, 63);
        chk("t1_done_cnt", n_done, 1);
        chk("t1_busy_after", int'(busy), 0);
        chk("t1_overlap", overlap_err, 0);
        chk_syms("t1", 64);

        // Status never finishes, poll limit of 3
        fin_after = 1000; lat = 1;
        clr_log();
        pulse_start();
        wait_end(300, "t2");
        chk("t2_status_reads", nstat, 3);
        chk("t2_timeout_cnt", n_tmo, 1);
        chk("t2_dvalid_cycles", n_dv, 0);
        chk("t2_done_cnt", n_done, 0);
        chk("t2_busy_after", int'(busy), 0);

        // Known symbol pattern, finished at first poll, two-cycle latency
        mem[1] = 64'h0000_0000_0000_00E4;
        mem[2] = 64'h5555_5555_5555_5555;
        fin_after = 0; lat = 2;
        clr_log();
        pulse_start();
        wait_end(500, "t3");
        chk("t3_status_reads", nstat, 1);
        chk("t3_nsym", nsym, 64);
        chk("t3_sym0", int'(sym[0]), 0);
        chk("t3_sym1", int'(sym[1]), 1);
        chk("t3_sym2", int'(sym[2]), 2);
        chk("t3_sym3", int'(sym[3]), 3);
        nz = 0;
        for (int i = 4; i < 32; i++) if (sym[i] != 2'd0) nz++;
        chk("t3_zero_tail", nz, 0);
        chk("t3_word1_sym40", int'(sym[40]), 1);

        // Five waitrequest cycles on the address-1 read
        mem[1] = 64'hA5A5_0F0F_3C3C_9696;
        mem[2] = 64'h1122_3344_5566_7788;
        wait_arm = 1'b1; lat = 1; fin_after = 0;
        clr_log();
        pulse_start();
        wait_end(500, "t4");
        chk("t4_wait_cycles", ws_cyc, 5);
        chk("t4_avm_stable", avm_stab_err, 0);
        chk("t4_addr1_accepts", n_a1, 1);
        chk("t4_nsym", nsym, 64);
        chk("t4_done_cnt", n_done, 1);
        chk_syms("t4", 64);
        wait_arm = 1'b0;

        // Downstream stalls with ready pattern 1,0,0,1
        mem[1] = 64'hDEAD_BEEF_CAFE_F00D;
        mem[2] = 64'h0F1E_2D3C_4B5A_6978;
        rdy_mode = 1; lat = 1; fin_after = 1;
        clr_log();
        pulse_start();
        wait_end(1000, "t5");
        chk("t5_nsym", nsym, 64);
        chk("t5_data_stable", dat_stab_err, 0);
        chk("t5_addr2_after_syms", sym_at_a2, 32);
        chk("t5_overlap", overlap_err, 0);
        chk("t5_done_cnt", n_done, 1);
        chk_syms("t5", 64);
        rdy_mode = 0;

        // Reset mid-drain, stray readdatavalid in idle, then a clean transfer
        mem[1] = 64'h1357_9BDF_2468_ACE0;
        mem[2] = 64'h8899_AABB_CCDD_EEFF;
        lat = 1; fin_after = 0;
        clr_log();
        pulse_start();
        k = 0;
        while (nsym < 10 && k < 300) begin
            @(posedge clk);
            k++;
        end
        chk("t6_reached_drain", int'(nsym >= 10), 1);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("t6_rst");
        rst = 1'b1;
        clr_log();
        @(negedge clk); force_rdv = 1'b1;
        @(negedge clk); force_rdv = 1'b0;
        repeat (10) @(posedge clk);
        chk("t6_stray_dvalid", n_dv, 0);
        chk("t6_stray_busy", int'(busy), 0);
        chk("t6_stray_reads", nstat + ndata, 0);
        clr_log();
        pulse_start();
        wait_end(500, "t6");
        chk("t6_nsym", nsym, 64);
        chk("t6_status_reads", nstat, 1);
        chk("t6_nlast", nlast, 1);
        chk("t6_done_cnt", n_done, 1);
        chk_syms("t6", 64);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/med_result_reader.md
Name: med_result_reader

Overview:
- Avalon-MM read initiator for the sequence-aligner result region.
- Polls the solver status word until the finished bit is set, then reads NUM_WORDS packed 64-bit result words.
- Unpacks each word into 32 two-bit direction symbols and streams them out over a valid/ready interface.
- Sits between the solver's memory-mapped responder and downstream traceback/host-logging logic.

Parameters:
- NUM_WORDS, 2, number of 64-bit result words read after finished (1..62)
- POLL_GAP, 4, idle cycles between consecutive status polls (0 allowed)
- POLL_LIMIT, 1024, maximum status polls before timeout (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a transfer when idle
- busy  out  1  high from accepted start until DONE or TIMEOUT
- done  out  1  one-cycle pulse after the last symbol is accepted
- timeout  out  1  one-cycle pulse when POLL_LIMIT is exhausted
- avm_address  out  6  word address (0 = status, 1..NUM_WORDS = data)
- avm_read  out  1  read request
- avm_waitrequest  in  1  responder stall
- avm_readdata  in  64  read data
- avm_readdatavalid  in  1  read data valid
- dir_data  out  2  direction symbol (datatypesPkg direction encoding)
- dir_valid  out  1  symbol valid
- dir_ready  in  1  downstream ready
- dir_last  out  1  marks symbol NUM_WORDS*32-1

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE.
  - All outputs 0: avm_address, avm_read, busy, done, timeout, dir_valid, dir_last, dir_data.
  - Poll counter, gap counter, word index and symbol index all cleared.
  - Reset mid-transfer abandons the transfer; a late avm_readdatavalid arriving in IDLE is ignored.
- Avalon rules:
  - At most one read outstanding.
  - avm_read and avm_address are held stable while avm_waitrequest is high.
  - The request is accepted on the first edge with avm_read=1 and avm_waitrequest=0; avm_read drops the next cycle.
  - Read data is captured on the edge where avm_readdatavalid=1; it may arrive in the same cycle as acceptance or later.
- IDLE: start=1 -> POLL_REQ, busy=1, poll counter=0. start while busy is ignored.
- POLL_REQ: drive address 0 with avm_read=1. On acceptance -> POLL_WAIT and increment the poll counter.
- POLL_WAIT: on readdatavalid:
  - if readdata[0]==1 -> DATA_REQ, word index=0;
  - else if poll counter==POLL_LIMIT -> TIMEOUT;
  - else -> POLL_GAP (or POLL_REQ directly if POLL_GAP==0).
  - Bits 63:1 of the status word are ignored.
- POLL_GAP: count POLL_GAP cycles, then -> POLL_REQ.
- DATA_REQ: drive address word_index+1 with avm_read=1. On acceptance -> DATA_WAIT.
- DATA_WAIT: on readdatavalid, load the word into the unpacker -> DRAIN.
- DRAIN:
  - Emits symbols 0..31 of the word, symbol i = bits[2i+1:2i], ascending.
  - One symbol per cycle while dir_ready=1. dir_valid stays high and dir_data stays stable while dir_ready=0.
  - After symbol 31 is accepted: if word_index==NUM_WORDS-1 -> DONE, else increment word_index -> DATA_REQ.
  - No Avalon read is issued while draining.
- dir_last=1 only together with the final symbol of the final word.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- TIMEOUT: timeout=1 for one cycle, busy=0, no symbols emitted -> IDLE.
- Latency: minimum of 1 cycle from readdatavalid of a data word to dir_valid.
- A start pulse in the same cycle as done or timeout is ignored; start is accepted only in IDLE.

Decomposition:
- datatypesPkg:
  - reuse direction and dna_base;
  - add constants MED_STATUS_ADDR=6'd0, MED_DATA_BASE=6'd1, MED_SYMS_PER_WORD=32;
  - add the reader state enum typedef med_rd_state.
- Sub-module med_dir_unpacker: loads a 64-bit word, shifts 2 bits per handshake, and provides valid/ready, a symbol index and a last-of-word flag.

Test Plan:
- Status returns 0,0,1 with POLL_GAP=4 and no waitrequest -> exactly 3 reads at address 0 separated by 4 idle cycles, then reads at addresses 1 and 2; 64 symbols emitted, dir_last on the 64th; done pulses once.
- Status always 0 with POLL_LIMIT=3 -> exactly 3 status reads, timeout pulses once, dir_valid never asserted, busy returns to 0.
- Data word 0 = 64'h0000_0000_0000_00E4, finished at first poll -> first four symbols 0,1,2,3, then 28 zeros.
- avm_waitrequest held high for 5 cycles on the address-1 read -> avm_read and avm_address=1 stable for all 5 cycles, a single request accepted, data correct.
- dir_ready toggled 1,0,0,1,... during DRAIN -> no symbol lost or duplicated, dir_data stable while stalled, address 2 read only after all 32 symbols of word 0 are accepted.
- rst driven low in DRAIN mid-word, readdatavalid then pulsed in IDLE -> all outputs 0, nothing emitted; a new start performs a clean full transfer.
